dmem_responder: RTL

//  Data-memory responder for the multi-cycle core's VISIT_MEM stage. Accepts the one-cycle

---
 rtl/dmem_responder_pkg.sv | 20 ++
 rtl/dmem_watchdog.sv | 32 +++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the FSM state encodings, the err_code values and a small alignment helper.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10,
        ST_ERR    = 2'b11
    } dmem_state_t;

    localparam logic [1:0] DMEM_ERR_MISALIGN = 2'b01;
    localparam logic [1:0] DMEM_ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] DMEM_ERR_LDST     = 2'b11;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// Clear/enable cycle counter that flags expiry once LIMIT enabled cycles have elapsed.
// Used by dmem_responder only in DMEM_TIMEOUT_EN builds.
module dmem_watchdog
    import dmem_responder_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    // Expiry is flagged during the LIMIT-th enabled cycle so the owner can react on that edge.
    assign expired = (count == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// VISIT_MEM-stage data-memory responder: one word access per strobe on a req/ack RAM port.
// Build macro DMEM_TIMEOUT_EN adds an ACCESS watchdog (TIMEOUT_CYC) that aborts with err_code 10.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          visit_mem,
    input  logic          is_load,
    input  logic          is_store,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ld_data,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic [1:0]    err_code
);

    dmem_state_t   state;
    dmem_state_t   next_state;

    logic          next_req;
    logic          next_we;
    logic [AW-1:0] next_addr;
    logic [DW-1:0] next_wdata;
    logic [DW-1:0] next_ld_data;
    logic [1:0]    next_err_code;
    logic          timeout;

`ifdef DMEM_TIMEOUT_EN
    dmem_watchdog #(
        .LIMIT   (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != ST_ACCESS),
        .enable  ((state == ST_ACCESS) && !mem_ack),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Strobes outside IDLE and acks outside ACCESS fall through to the hold defaults.
    always_comb begin
        next_state    = state;
        next_req      = mem_req;
        next_we       = mem_we;
        next_addr     = mem_addr;
        next_wdata    = mem_wdata;
        next_ld_data  = ld_data;
        next_err_code = err_code;

        case (state)
            ST_IDLE: begin
                if (visit_mem) begin
                    if (is_load && is_store) begin
                        next_state    = ST_ERR;
                        next_err_code = DMEM_ERR_LDST;
                    end else if (is_load || is_store) begin
                        if (!is_word_aligned(addr[1:0])) begin
                            next_state    = ST_ERR;
                            next_err_code = DMEM_ERR_MISALIGN;
                        end else begin
                            next_state = ST_ACCESS;
                            next_req   = 1'b1;
                            next_we    = is_store;
                            next_addr  = {addr[AW-1:2], 2'b00};
                            next_wdata = wdata;
                        end
                    end
                end
            end

            ST_ACCESS: begin
                // An ack in the expiry cycle still completes the access normally.
                if (mem_ack) begin
                    next_state = ST_DONE;
                    next_req   = 1'b0;
                    if (!mem_we) begin
                        next_ld_data = mem_rdata;
                    end
                end else if (timeout) begin
                    next_state    = ST_ERR;
                    next_req      = 1'b0;
                    next_err_code = DMEM_ERR_TIMEOUT;
                end
            end

            ST_DONE: begin
                next_state = ST_IDLE;
            end

            ST_ERR: begin
                next_state = ST_IDLE;
            end

            default: begin
                next_state = ST_IDLE;
                next_req   = 1'b0;
            end
        endcase
    end

    // Status pulses are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ld_data   <= '0;
            err_code  <= 2'b00;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            mem_req   <= next_req;
            mem_we    <= next_we;
            mem_addr  <= next_addr;
            mem_wdata <= next_wdata;
            ld_data   <= next_ld_data;
            err_code  <= next_err_code;
            done      <= (next_state == ST_DONE);
            err       <= (next_state == ST_ERR);
            busy      <= (next_state != ST_IDLE);
        end
    end

endmodule
